// File: rtl/i2c_arb_pkg.sv
// Shared types for the I2C master arbiter: FSM states, latched request payload
// and the supported requester limit.
package i2c_arb_pkg;

    localparam int unsigned I2C_ARB_MAX_REQ = 8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        BUSY,
        DONE,
        GAP
    } arb_state_t;

    typedef struct packed {
        logic [6:0] addr;
        logic       wlen;
        logic [7:0] wdata1;
        logic [7:0] wdata2;
        logic       read;
    } i2c_req_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first asserted request at or
// after ptr, wrapping modulo NREQ.
module rr_pick
    import i2c_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   idx,
    output logic [NREQ-1:0] onehot
);

    logic [NREQ-1:0] w_rot;
    int unsigned     w_sel;

    // Bit k of w_rot is client (ptr + k) mod NREQ.
    assign w_rot = (req >> ptr) | (req << (NREQ - 32'(ptr)));

    always_comb begin
        valid  = 1'b0;
        w_sel  = 0;
        onehot = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!valid && w_rot[k]) begin
                valid = 1'b1;
                w_sel = 32'(ptr) + k;
            end
        end
        if (w_sel >= NREQ) w_sel = w_sel - NREQ;
        idx = IW'(w_sel);
        for (int unsigned i = 0; i < NREQ; i++) onehot[i] = valid && (w_sel == i);
    end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master between NREQ register clients.
// Optional watchdog abort is enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int unsigned NREQ        = 2,
    parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*7-1:0] req_addr,
    input  logic [NREQ-1:0]   req_wlen,
    input  logic [NREQ*8-1:0] req_wdata1,
    input  logic [NREQ*8-1:0] req_wdata2,
    input  logic [NREQ-1:0]   req_read,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic              ack,
    output logic [7:0]        rdata,
    output logic              timeout,
    output logic              M_START,
    output logic [6:0]        M_ADDR,
    output logic              M_WLEN,
    output logic [7:0]        M_WDATA1,
    output logic [7:0]        M_WDATA2,
    output logic              M_READ,
    input  logic              M_END,
    input  logic              M_ACK,
    input  logic [7:0]        M_RDATA
);

    localparam int unsigned IW = $clog2(NREQ);

    arb_state_t      r_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_owner;
    i2c_req_t        r_pay;
    logic [NREQ-1:0] r_grant;
    logic [NREQ-1:0] r_done;
    logic            r_ack;
    logic [7:0]      r_rdata;
    logic            r_start;
    logic            r_timeout;

    logic            w_valid;
    logic [IW-1:0]   w_idx;
    logic [NREQ-1:0] w_onehot;
    logic            w_wd_hit;
    i2c_req_t        w_req [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_req[g] = {req_addr[g*7 +: 7], req_wlen[g], req_wdata1[g*8 +: 8],
                           req_wdata2[g*8 +: 8], req_read[g]};
    end

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .valid  (w_valid),
        .idx    (w_idx),
        .onehot (w_onehot)
    );

`ifdef I2C_ARB_TIMEOUT_EN
    logic [31:0] r_wd;

    // Held at zero outside ISSUE/BUSY, so it starts from zero on ISSUE entry.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)                               r_wd <= '0;
        else if (r_state == ISSUE || r_state == BUSY) r_wd <= r_wd + 32'd1;
        else                                       r_wd <= '0;
    end

    assign w_wd_hit = (r_state == ISSUE || r_state == BUSY) && (r_wd == 32'(TIMEOUT_CYC - 1));
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYC == 0);
    assign w_wd_hit = 1'b0;
`endif

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_pay     <= '0;
            r_grant   <= '0;
            r_done    <= '0;
            r_ack     <= 1'b0;
            r_rdata   <= '0;
            r_start   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_done <= '0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_grant <= w_onehot;
                        r_owner <= w_idx;
                        r_pay   <= w_req[w_idx];
                        r_start <= 1'b1;
                        r_state <= ISSUE;
                    end else begin
                        r_start <= 1'b0;
                    end
                end
                ISSUE, BUSY: begin
                    if (w_wd_hit) begin
                        r_start   <= 1'b0;
                        r_ack     <= 1'b1;
                        r_rdata   <= '0;
                        r_timeout <= 1'b1;
                        r_done    <= r_grant;
                        r_state   <= DONE;
                    end else if (r_state == ISSUE) begin
                        if (!M_END) begin
                            r_start <= 1'b0;
                            r_state <= BUSY;
                        end
                    end else if (M_END) begin
                        r_ack   <= M_ACK;
                        r_rdata <= M_RDATA;
                        r_done  <= r_grant;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_grant <= '0;
                    r_ptr   <= (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + IW'(1);
                    r_state <= GAP;
                end
                GAP:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grant    = r_grant;
    assign done     = r_done;
    assign ack      = r_ack;
    assign rdata    = r_rdata;
    assign timeout  = r_timeout;
    assign M_START  = r_start;
    assign M_ADDR   = r_pay.addr;
    assign M_WLEN   = r_pay.wlen;
    assign M_WDATA1 = r_pay.wdata1;
    assign M_WDATA2 = r_pay.wdata2;
    assign M_READ   = r_pay.read;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Self-checking bench for i2c_arbiter: timestamp-based transfer model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_i2c_arbiter;

    localparam int NREQ = 2;
    localparam int TO   = 100;
`ifdef I2C_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              iCLK = 1'b0;
    logic              iRST_N = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*7-1:0] req_addr = '0;
    logic [NREQ-1:0]   req_wlen = '0;
    logic [NREQ*8-1:0] req_wdata1 = '0;
    logic [NREQ*8-1:0] req_wdata2 = '0;
    logic [NREQ-1:0]   req_read = '0;
    logic [NREQ-1:0]   grant, done;
    logic              ack, timeout, M_START, M_WLEN, M_READ;
    logic [7:0]        rdata, M_WDATA1, M_WDATA2;
    logic [6:0]        M_ADDR;
    logic              M_END = 1'b1;
    logic              M_ACK = 1'b0;
    logic [7:0]        M_RDATA = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 iCLK = ~iCLK;

    i2c_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .req(req), .req_addr(req_addr),
        .req_wlen(req_wlen), .req_wdata1(req_wdata1), .req_wdata2(req_wdata2),
        .req_read(req_read), .grant(grant), .done(done), .ack(ack), .rdata(rdata),
        .timeout(timeout), .M_START(M_START), .M_ADDR(M_ADDR), .M_WLEN(M_WLEN),
        .M_WDATA1(M_WDATA1), .M_WDATA2(M_WDATA2), .M_READ(M_READ),
        .M_END(M_END), .M_ACK(M_ACK), .M_RDATA(M_RDATA)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    // I2C master stand-in: END idles high, drops on an accepted START,
    // rises again after m_dur cycles unless hung.
    int         m_dur = 10;
    int         m_cnt = 0;
    bit         m_run = 1'b0;
    bit         m_hang = 1'b0;
    logic       m_ack_cfg = 1'b0;
    logic [7:0] m_rd_cfg = '0;

    always @(posedge iCLK) begin
        if (m_run) begin
            if (!m_hang && m_cnt <= 1) begin
                M_END   <= 1'b1;
                M_ACK   <= m_ack_cfg;
                M_RDATA <= m_rd_cfg;
                m_run   <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (M_START && M_END) begin
            M_END <= 1'b0;
            m_run <= 1'b1;
            m_cnt <= m_dur;
        end
    end

    // Transfer model in terms of edge timestamps: grant edge g_e, the edge
    // where the finished END is seen f_e, earliest next arbitration free_e.
    int         cyc, free_e, g_e, f_e, owner, ptr;
    bit         own, acc, fin, done_now, to_m;
    logic       ack_m, ew, er;
    logic [7:0] rd_m, e1, e2;
    logic [6:0] ea;

    always @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cyc = 0; free_e = 0; g_e = 0; f_e = 0; owner = 0; ptr = 0;
            own = 0; acc = 0; fin = 0; done_now = 0; to_m = 0;
            ack_m = 0; rd_m = 0; ea = 0; ew = 0; e1 = 0; e2 = 0; er = 0;
        end else begin
            cyc++;
            done_now = 0;
            if (own && fin && cyc == f_e + 1) begin
                own = 0;
                ptr = (owner + 1) % NREQ;
                free_e = cyc + 2;
            end else if (own && !fin && TO_EN && (cyc - g_e == TO)) begin
                fin = 1; f_e = cyc; ack_m = 1; rd_m = 0; to_m = 1; done_now = 1;
            end else if (own && !acc && !fin) begin
                if (!M_END) acc = 1;
            end else if (own && acc && !fin && M_END) begin
                fin = 1; f_e = cyc; ack_m = M_ACK; rd_m = M_RDATA; done_now = 1;
            end else if (!own && cyc >= free_e && req != 0) begin
                for (int k = 0; k < NREQ; k++) begin
                    int j;
                    j = (ptr + k) % NREQ;
                    if (!own && req[j]) begin
                        own = 1; owner = j; g_e = cyc; acc = 0; fin = 0;
                        ea = req_addr[j*7 +: 7];  ew = req_wlen[j];
                        e1 = req_wdata1[j*8 +: 8]; e2 = req_wdata2[j*8 +: 8];
                        er = req_read[j];
                    end
                end
            end
        end
    end

    always @(negedge iCLK) begin
        if (iRST_N) begin
            chk("m_grant",   grant,   own ? (1 << owner) : 0);
            chk("m_onehot0", $onehot0(grant), 1);
            chk("m_done",    done,    done_now ? (1 << owner) : 0);
            chk("m_start",   M_START, own && !acc && !fin);
            chk("m_ack",     ack,     ack_m);
            chk("m_rdata",   rdata,   rd_m);
            chk("m_timeout", timeout, to_m);
            chk("m_addr",    M_ADDR,  ea);
            chk("m_wlen",    M_WLEN,  ew);
            chk("m_wdata1",  M_WDATA1, e1);
            chk("m_wdata2",  M_WDATA2, e2);
            chk("m_read",    M_READ,  er);
        end
    end

    int         order_q[$];
    logic       ack_q[$];
    logic [7:0] rd_q[$];

    task automatic set_pay(input int i, input logic [6:0] a, input logic wl,
                           input logic [7:0] d1, input logic [7:0] d2, input logic rd);
        req_addr[i*7 +: 7]   = a;
        req_wlen[i]          = wl;
        req_wdata1[i*8 +: 8] = d1;
        req_wdata2[i*8 +: 8] = d2;
        req_read[i]          = rd;
    endtask

    // Collect n done pulses; the client drops req on its done.
    task automatic run_dones(input int n, input int budget);
        int got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            @(negedge iCLK);
            for (int i = 0; i < NREQ; i++) begin
                if (done[i]) begin
                    order_q.push_back(i);
                    ack_q.push_back(ack);
                    rd_q.push_back(rdata);
                    req[i] = 1'b0;
                    got++;
                end
            end
        end
        chk("run_dones_count", got, n);
    endtask

    task automatic wait_master_idle();
        bit ok = 0;
        for (int c = 0; c < 500 && !ok; c++) begin
            @(negedge iCLK);
            ok = !m_run && M_END;
        end
        chk("master_idle", ok, 1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_grant"},  grant, 0);
        chk({nm, "_done"},   done, 0);
        chk({nm, "_ackrd"},  {ack, rdata, timeout}, 0);
        chk({nm, "_mstart"}, M_START, 0);
        chk({nm, "_mpay"},   {M_ADDR, M_WLEN, M_WDATA1, M_WDATA2, M_READ}, 0);
    endtask

    task automatic do_reset();
        @(negedge iCLK);
        iRST_N = 1'b0;
        req = '0;
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
    endtask

    initial begin
        int seq, nd, c;

        repeat (3) @(negedge iCLK);
        chk_all_zero("rst_hold");
        iRST_N = 1'b1;
        @(negedge iCLK);
        chk_all_zero("rst_after");

        // Single client, two-byte write
        set_pay(0, 7'h39, 1'b1, 8'h98, 8'h03, 1'b0);
        m_dur = 50; m_ack_cfg = 1'b0;
        req[0] = 1'b1;
        @(negedge iCLK);
        chk("t1_grant_latency", grant, 2'b01);
        chk("t1_start_latency", M_START, 1);
        chk("t1_payload", {M_ADDR, M_WLEN, M_WDATA1, M_WDATA2}, {7'h39, 1'b1, 8'h98, 8'h03});
        run_dones(1, 200);
        if (order_q.size() == 1) begin
            chk("t1_owner", order_q[0], 0);
            chk("t1_ack", ack_q[0], 0);
        end
        @(negedge iCLK);
        chk("t1_grant_drop", grant, 2'b00);
        chk("t1_done_single", done, 2'b00);

        // Simultaneous requests from reset, twice
        wait_master_idle();
        do_reset();
        order_q.delete(); ack_q.delete(); rd_q.delete();
        set_pay(0, 7'h10, 1'b0, 8'h01, 8'h00, 1'b0);
        set_pay(1, 7'h20, 1'b0, 8'h02, 8'h00, 1'b0);
        m_dur = 10;
        @(negedge iCLK);
        req = 2'b11;
        run_dones(2, 200);
        req = 2'b11;
        run_dones(2, 200);
        seq = 0;
        foreach (order_q[i]) seq = seq * 10 + order_q[i];
        chk("t2_count", order_q.size(), 4);
        chk("t2_order", seq, 101);

        // Read on client 1
        wait_master_idle();
        order_q.delete(); ack_q.delete(); rd_q.delete();
        set_pay(1, 7'h50, 1'b0, 8'h00, 8'h00, 1'b1);
        m_rd_cfg = 8'hA5; m_dur = 20;
        req[1] = 1'b1;
        run_dones(1, 200);
        if (order_q.size() == 1) begin
            chk("t3_owner", order_q[0], 1);
            chk("t3_rdata_at_done", rd_q[0], 8'hA5);
        end
        repeat (5) @(negedge iCLK);
        chk("t3_rdata_held", rdata, 8'hA5);

        // NACK, payload change and dropped request during BUSY
        wait_master_idle();
        order_q.delete(); ack_q.delete(); rd_q.delete();
        set_pay(0, 7'h21, 1'b0, 8'h5A, 8'h00, 1'b0);
        m_ack_cfg = 1'b1; m_dur = 30;
        req[0] = 1'b1;
        repeat (6) @(negedge iCLK);
        chk("t4_busy_start_low", {grant, M_START}, {2'b01, 1'b0});
        req_wdata1[7:0] = 8'hFF;
        req_addr[6:0]   = 7'h7F;
        req[0] = 1'b0;
        run_dones(1, 200);
        if (order_q.size() == 1) begin
            chk("t4_owner", order_q[0], 0);
            chk("t4_nack", ack_q[0], 1);
        end
        chk("t4_wdata1_stable", M_WDATA1, 8'h5A);
        chk("t4_addr_stable", M_ADDR, 7'h21);
        m_ack_cfg = 1'b0;

        // Asynchronous reset in the middle of a transfer
        wait_master_idle();
        set_pay(1, 7'h33, 1'b0, 8'h11, 8'h00, 1'b0);
        m_dur = 40;
        req[1] = 1'b1;
        repeat (10) @(negedge iCLK);
        chk("t5_granted", {grant, M_ADDR}, {2'b10, 7'h33});
        #2;
        iRST_N = 1'b0;
        #1;
        chk_all_zero("t5_async");
        req = '0;
        @(negedge iCLK);
        iRST_N = 1'b1;
        nd = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge iCLK);
            if (done != 0) nd++;
        end
        chk("t5_late_end_ignored", nd, 0);
        chk("t5_master_finished", M_END, 1);

`ifdef I2C_ARB_TIMEOUT_EN
        // Hung master: watchdog aborts each owner in turn
        wait_master_idle();
        order_q.delete(); ack_q.delete(); rd_q.delete();
        set_pay(0, 7'h44, 1'b0, 8'h01, 8'h00, 1'b0);
        set_pay(1, 7'h45, 1'b0, 8'h02, 8'h00, 1'b0);
        m_hang = 1'b1;
        req = 2'b11;
        c = 0;
        for (int i = 1; i <= TO + 5 && c == 0; i++) begin
            @(negedge iCLK);
            if (done != 0) c = i;
        end
        chk("t6_wd_fired", c != 0, 1);
        chk("t6_wd_latency", c <= TO + 1, 1);
        chk("t6_wd_result", {done, ack, rdata, timeout}, {2'b01, 1'b1, 8'h00, 1'b1});
        req[0] = 1'b0;
        run_dones(1, TO + 20);
        if (order_q.size() == 1) chk("t6_next_owner", order_q[0], 1);
`endif

        repeat (3) @(negedge iCLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 1000000");
        $fatal(1);
    end

endmodule
